// File: rtl/scarv_cop_txn_monitor.sv
// Transaction monitor for the COP: assembles one record per instruction (plus its memory
// traffic) and queues it for a valid/ready consumer. Define TXN_MONITOR_TIMESTAMP_EN for cycle stamps.
module scarv_cop_txn_monitor #(
    parameter int unsigned MEM_DEPTH      = 4,
    parameter int unsigned TXN_FIFO_DEPTH = 4,
    parameter int unsigned DROP_W         = 8
) (
    input  logic                           g_clk,
    input  logic                           g_reset,
    input  logic                           cpu_insn_req,
    input  logic                           cop_insn_ack,
    input  logic                           cpu_abort_req,
    input  logic [31:0]                    cpu_insn_enc,
    input  logic [31:0]                    cpu_rs1,
    input  logic                           cop_insn_rsp,
    input  logic                           cpu_insn_ack,
    input  logic [2:0]                     cop_result,
    input  logic                           cop_wen,
    input  logic [4:0]                     cop_waddr,
    input  logic [31:0]                    cop_wdata,
    input  logic                           cop_mem_cen,
    input  logic                           cop_mem_wen,
    input  logic [31:0]                    cop_mem_addr,
    input  logic [31:0]                    cop_mem_wdata,
    input  logic [3:0]                     cop_mem_ben,
    input  logic [31:0]                    cop_mem_rdata,
    input  logic                           cop_mem_stall,
    input  logic                           cop_mem_error,
    output logic                           trc_valid,
    input  logic                           trc_ready,
    output logic [31:0]                    trc_enc,
    output logic [31:0]                    trc_rs1,
    output logic [2:0]                     trc_result,
    output logic                           trc_wen,
    output logic [4:0]                     trc_waddr,
    output logic [31:0]                    trc_wdata,
    output logic                           trc_aborted,
    output logic [$clog2(MEM_DEPTH)+1:0]   trc_mem_cnt,
    output logic                           trc_mem_ovf,
    output logic [MEM_DEPTH-1:0]           trc_mem_wen,
    output logic [MEM_DEPTH-1:0]           trc_mem_err,
    output logic [4*MEM_DEPTH-1:0]         trc_mem_ben,
    output logic [32*MEM_DEPTH-1:0]        trc_mem_addr,
    output logic [32*MEM_DEPTH-1:0]        trc_mem_wdata,
    output logic [32*MEM_DEPTH-1:0]        trc_mem_rdata,
`ifdef TXN_MONITOR_TIMESTAMP_EN
    output logic [31:0]                    trc_t_start,
    output logic [31:0]                    trc_t_end,
`endif
    output logic [DROP_W-1:0]              trc_drop_cnt,
    output logic                           trc_stray
);

    localparam int unsigned CW = $clog2(MEM_DEPTH) + 2;
    localparam int unsigned AW = $clog2(TXN_FIFO_DEPTH);

    typedef struct packed {
        logic [31:0]             enc;
        logic [31:0]             rs1;
        logic [2:0]              result;
        logic                    wen;
        logic [4:0]              waddr;
        logic [31:0]             wdata;
        logic                    aborted;
        logic [CW-1:0]           mem_cnt;
        logic                    mem_ovf;
        logic [MEM_DEPTH-1:0]    mem_wen;
        logic [MEM_DEPTH-1:0]    mem_err;
        logic [4*MEM_DEPTH-1:0]  mem_ben;
        logic [32*MEM_DEPTH-1:0] mem_addr;
        logic [32*MEM_DEPTH-1:0] mem_wdata;
        logic [32*MEM_DEPTH-1:0] mem_rdata;
`ifdef TXN_MONITOR_TIMESTAMP_EN
        logic [31:0]             t_start;
        logic [31:0]             t_end;
`endif
    } rec_t;

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e state_q, state_d;
    rec_t   cur_q, cur_d, upd, new_rec, rec_push, head;
    logic   push, pop, do_push, drop, full, empty;
    logic   txn, acc, rsp;
    int     idx;

    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic [DROP_W-1:0] drop_cnt_q;
    logic              stray_q;
    rec_t              fifo_q [TXN_FIFO_DEPTH];

`ifdef TXN_MONITOR_TIMESTAMP_EN
    logic [31:0] ts_q;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) ts_q <= '0;
        else         ts_q <= ts_q + 32'd1;
    end
`endif

    assign txn = cop_mem_cen && !cop_mem_stall;
    assign acc = cpu_insn_req && cop_insn_ack;
    assign rsp = cop_insn_rsp && cpu_insn_ack;
    assign idx = int'(cur_q.mem_cnt);

    // Fold this cycle's memory txn into the open record so a close sees it.
    always_comb begin
        upd = cur_q;
        if (state_q == StActive && txn) begin
            if (cur_q.mem_cnt < CW'(MEM_DEPTH)) begin
                upd.mem_wen[idx]              = cop_mem_wen;
                upd.mem_err[idx]              = cop_mem_error;
                upd.mem_ben[idx*4 +: 4]       = cop_mem_ben;
                upd.mem_addr[idx*32 +: 32]    = cop_mem_addr;
                upd.mem_wdata[idx*32 +: 32]   = cop_mem_wdata;
                upd.mem_rdata[idx*32 +: 32]   = cop_mem_rdata;
            end
            if (cur_q.mem_cnt != '1) upd.mem_cnt = cur_q.mem_cnt + CW'(1);
        end
        upd.mem_ovf = (upd.mem_cnt > CW'(MEM_DEPTH));
    end

    always_comb begin
        new_rec     = '0;
        new_rec.enc = cpu_insn_enc;
        new_rec.rs1 = cpu_rs1;
`ifdef TXN_MONITOR_TIMESTAMP_EN
        new_rec.t_start = ts_q;
`endif
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = upd;
        push     = 1'b0;
        rec_push = upd;
`ifdef TXN_MONITOR_TIMESTAMP_EN
        rec_push.t_end = ts_q;
`endif
        case (state_q)
            StIdle: begin
                if (acc) begin
                    state_d = StActive;
                    cur_d   = new_rec;
                end
            end
            StActive: begin
                // Response beats abort when both arrive together.
                if (rsp) begin
                    push             = 1'b1;
                    rec_push.result  = cop_result;
                    rec_push.wen     = cop_wen;
                    rec_push.waddr   = cop_waddr;
                    rec_push.wdata   = cop_wdata;
                    rec_push.aborted = 1'b0;
                end else if (cpu_abort_req) begin
                    push             = 1'b1;
                    rec_push.aborted = 1'b1;
                end
                if (push) begin
                    if (acc) cur_d   = new_rec;
                    else     state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= StIdle;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
        end
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = !empty && trc_ready;
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge g_clk) begin
        if (do_push) fifo_q[wr_ptr_q[AW-1:0]] <= rec_push;
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
            stray_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
            if (state_q == StIdle && txn) stray_q <= 1'b1;
        end
    end

    // Memory contents are never reset, so gate the head with empty to keep outputs at 0.
    always_comb begin
        head = '0;
        if (!empty) head = fifo_q[rd_ptr_q[AW-1:0]];
    end

    assign trc_valid     = !empty;
    assign trc_enc       = head.enc;
    assign trc_rs1       = head.rs1;
    assign trc_result    = head.result;
    assign trc_wen       = head.wen;
    assign trc_waddr     = head.waddr;
    assign trc_wdata     = head.wdata;
    assign trc_aborted   = head.aborted;
    assign trc_mem_cnt   = head.mem_cnt;
    assign trc_mem_ovf   = head.mem_ovf;
    assign trc_mem_wen   = head.mem_wen;
    assign trc_mem_err   = head.mem_err;
    assign trc_mem_ben   = head.mem_ben;
    assign trc_mem_addr  = head.mem_addr;
    assign trc_mem_wdata = head.mem_wdata;
    assign trc_mem_rdata = head.mem_rdata;
`ifdef TXN_MONITOR_TIMESTAMP_EN
    assign trc_t_start   = head.t_start;
    assign trc_t_end     = head.t_end;
`endif
    assign trc_drop_cnt  = drop_cnt_q;
    assign trc_stray     = stray_q;

endmodule

// File: tb/tb_scarv_cop_txn_monitor.sv
// Directed bench for scarv_cop_txn_monitor with default parameters (4 slots, 4-entry FIFO).
module tb_scarv_cop_txn_monitor;

    localparam int unsigned MD = 4;
    localparam int unsigned CW = $clog2(MD) + 2;

    logic g_clk = 1'b0;
    logic g_reset;
    logic cpu_insn_req, cop_insn_ack, cpu_abort_req, cop_insn_rsp, cpu_insn_ack;
    logic [31:0] cpu_insn_enc, cpu_rs1, cop_wdata;
    logic [2:0]  cop_result;
    logic        cop_wen;
    logic [4:0]  cop_waddr;
    logic        cop_mem_cen, cop_mem_wen, cop_mem_stall, cop_mem_error;
    logic [31:0] cop_mem_addr, cop_mem_wdata, cop_mem_rdata;
    logic [3:0]  cop_mem_ben;
    logic        trc_valid, trc_ready;
    logic [31:0] trc_enc, trc_rs1, trc_wdata;
    logic [2:0]  trc_result;
    logic        trc_wen, trc_aborted, trc_mem_ovf, trc_stray;
    logic [4:0]  trc_waddr;
    logic [CW-1:0] trc_mem_cnt;
    logic [MD-1:0] trc_mem_wen, trc_mem_err;
    logic [4*MD-1:0] trc_mem_ben;
    logic [32*MD-1:0] trc_mem_addr, trc_mem_wdata, trc_mem_rdata;
    logic [7:0]  trc_drop_cnt;
`ifdef TXN_MONITOR_TIMESTAMP_EN
    logic [31:0] trc_t_start, trc_t_end;
`endif

    int checks = 0;
    int errors = 0;

    always #5 g_clk = ~g_clk;

    scarv_cop_txn_monitor #(
        .MEM_DEPTH      (MD),
        .TXN_FIFO_DEPTH (4),
        .DROP_W         (8)
    ) dut (
        .g_clk         (g_clk),
        .g_reset       (g_reset),
        .cpu_insn_req  (cpu_insn_req),
        .cop_insn_ack  (cop_insn_ack),
        .cpu_abort_req (cpu_abort_req),
        .cpu_insn_enc  (cpu_insn_enc),
        .cpu_rs1       (cpu_rs1),
        .cop_insn_rsp  (cop_insn_rsp),
        .cpu_insn_ack  (cpu_insn_ack),
        .cop_result    (cop_result),
        .cop_wen       (cop_wen),
        .cop_waddr     (cop_waddr),
        .cop_wdata     (cop_wdata),
        .cop_mem_cen   (cop_mem_cen),
        .cop_mem_wen   (cop_mem_wen),
        .cop_mem_addr  (cop_mem_addr),
        .cop_mem_wdata (cop_mem_wdata),
        .cop_mem_ben   (cop_mem_ben),
        .cop_mem_rdata (cop_mem_rdata),
        .cop_mem_stall (cop_mem_stall),
        .cop_mem_error (cop_mem_error),
        .trc_valid     (trc_valid),
        .trc_ready     (trc_ready),
        .trc_enc       (trc_enc),
        .trc_rs1       (trc_rs1),
        .trc_result    (trc_result),
        .trc_wen       (trc_wen),
        .trc_waddr     (trc_waddr),
        .trc_wdata     (trc_wdata),
        .trc_aborted   (trc_aborted),
        .trc_mem_cnt   (trc_mem_cnt),
        .trc_mem_ovf   (trc_mem_ovf),
        .trc_mem_wen   (trc_mem_wen),
        .trc_mem_err   (trc_mem_err),
        .trc_mem_ben   (trc_mem_ben),
        .trc_mem_addr  (trc_mem_addr),
        .trc_mem_wdata (trc_mem_wdata),
        .trc_mem_rdata (trc_mem_rdata),
`ifdef TXN_MONITOR_TIMESTAMP_EN
        .trc_t_start   (trc_t_start),
        .trc_t_end     (trc_t_end),
`endif
        .trc_drop_cnt  (trc_drop_cnt),
        .trc_stray     (trc_stray)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] enc, input logic [31:0] rs1);
        cpu_insn_req = 1'b1; cop_insn_ack = 1'b1; cpu_insn_enc = enc; cpu_rs1 = rs1;
        tick();
        cpu_insn_req = 1'b0; cop_insn_ack = 1'b0;
    endtask

    task automatic mem_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata);
        cop_mem_cen = 1'b1; cop_mem_wen = wen; cop_mem_addr = addr;
        cop_mem_wdata = wdata; cop_mem_rdata = rdata; cop_mem_ben = 4'hF;
        tick();
        cop_mem_cen = 1'b0;
    endtask

    task automatic respond(input logic [2:0] res, input logic wen, input logic [4:0] waddr,
                           input logic [31:0] wdata);
        cop_insn_rsp = 1'b1; cpu_insn_ack = 1'b1;
        cop_result = res; cop_wen = wen; cop_waddr = waddr; cop_wdata = wdata;
        tick();
        cop_insn_rsp = 1'b0; cpu_insn_ack = 1'b0; cop_wen = 1'b0;
    endtask

    initial begin
        g_reset = 1'b1;
        {cpu_insn_req, cop_insn_ack, cpu_abort_req, cop_insn_rsp, cpu_insn_ack} = '0;
        cpu_insn_enc = '0; cpu_rs1 = '0; cop_result = '0; cop_wen = 1'b0;
        cop_waddr = '0; cop_wdata = '0;
        {cop_mem_cen, cop_mem_wen, cop_mem_stall, cop_mem_error} = '0;
        cop_mem_addr = '0; cop_mem_wdata = '0; cop_mem_rdata = '0; cop_mem_ben = '0;
        trc_ready = 1'b0;
        tick(); tick();
        check("rst_valid", trc_valid, 1'b0);
        check("rst_enc", trc_enc, 32'h0);
        check("rst_drop", trc_drop_cnt, 8'h0);
        check("rst_stray", trc_stray, 1'b0);
        g_reset = 1'b0;
        tick();

        // Single instruction with two reads and one stalled cycle.
        accept(32'h0000_100B, 32'h1234);
        mem_txn(1'b0, 32'h100, 32'h0, 32'hAA);
        cop_mem_cen = 1'b1; cop_mem_stall = 1'b1; cop_mem_addr = 32'h999;
        tick();
        cop_mem_cen = 1'b0; cop_mem_stall = 1'b0;
        mem_txn(1'b0, 32'h104, 32'h0, 32'hBB);
        respond(3'd0, 1'b1, 5'd3, 32'h55);
        check("t1_valid", trc_valid, 1'b1);
        check("t1_enc", trc_enc, 32'h0000_100B);
        check("t1_rs1", trc_rs1, 32'h1234);
        check("t1_cnt", trc_mem_cnt, 4'd2);
        check("t1_ovf", trc_mem_ovf, 1'b0);
        check("t1_addr", trc_mem_addr, {32'h0, 32'h0, 32'h104, 32'h100});
        check("t1_rdata", trc_mem_rdata, {32'h0, 32'h0, 32'hBB, 32'hAA});
        check("t1_memwen", trc_mem_wen, 4'b0000);
        check("t1_wb", {trc_wen, trc_waddr, trc_wdata, trc_result, trc_aborted},
              {1'b1, 5'd3, 32'h55, 3'd0, 1'b0});
        tick();
        check("t1_hold", trc_enc, 32'h0000_100B);
        trc_ready = 1'b1;
        tick();
        trc_ready = 1'b0;
        check("t1_empty", trc_valid, 1'b0);

        // Slot overflow: six txns into four slots.
        accept(32'h0000_200B, 32'h0);
        for (int i = 1; i <= 6; i++) mem_txn(1'b0, 32'h10 * i, 32'h0, 32'h0);
        respond(3'd1, 1'b0, 5'd0, 32'h0);
        check("t2_cnt", trc_mem_cnt, 4'd6);
        check("t2_ovf", trc_mem_ovf, 1'b1);
        check("t2_addr", trc_mem_addr, {32'h40, 32'h30, 32'h20, 32'h10});
        check("t2_result", trc_result, 3'd1);
        trc_ready = 1'b1;
        tick();
        trc_ready = 1'b0;

        // Abort after one write.
        accept(32'h0000_300B, 32'h77);
        mem_txn(1'b1, 32'h80, 32'hDEAD, 32'h0);
        cpu_abort_req = 1'b1; cop_result = 3'd5; cop_wen = 1'b1; cop_wdata = 32'hFFFF;
        tick();
        cpu_abort_req = 1'b0; cop_wen = 1'b0;
        check("t3_abort", trc_aborted, 1'b1);
        check("t3_result", {trc_result, trc_wen, trc_wdata}, 36'h0);
        check("t3_cnt", trc_mem_cnt, 4'd1);
        check("t3_memwen", trc_mem_wen, 4'b0001);
        check("t3_wdata", trc_mem_wdata, {96'h0, 32'hDEAD});
        check("t3_ben", trc_mem_ben, 16'h000F);
        trc_ready = 1'b1;
        tick();

        // Response and new request together, twice, consumer always ready.
        accept(32'h0000_400B, 32'h0);
        cop_insn_rsp = 1'b1; cpu_insn_ack = 1'b1; cop_result = 3'd0;
        cpu_insn_req = 1'b1; cop_insn_ack = 1'b1; cpu_insn_enc = 32'h0000_500B;
        tick();
        check("t4_a", {trc_valid, trc_enc}, {1'b1, 32'h0000_400B});
        cpu_insn_enc = 32'h0000_600B;
        tick();
        check("t4_b", {trc_valid, trc_enc}, {1'b1, 32'h0000_500B});
        cpu_insn_req = 1'b0; cop_insn_ack = 1'b0;
        tick();
        check("t4_c", {trc_valid, trc_enc}, {1'b1, 32'h0000_600B});
        cop_insn_rsp = 1'b0; cpu_insn_ack = 1'b0;
        tick();
        check("t4_empty", trc_valid, 1'b0);
        trc_ready = 1'b0;

        // Six records into a four-entry FIFO with no consumer.
        for (int i = 0; i < 6; i++) begin
            accept(32'h1000_0000 + i, 32'h0);
            respond(3'd0, 1'b0, 5'd0, 32'h0);
        end
        check("t5_drop", trc_drop_cnt, 8'd2);
        check("t5_head0", {trc_valid, trc_enc}, {1'b1, 32'h1000_0000});
        trc_ready = 1'b1;
        tick();
        check("t5_head1", trc_enc, 32'h1000_0001);
        tick();
        check("t5_head2", trc_enc, 32'h1000_0002);
        tick();
        check("t5_head3", {trc_valid, trc_enc}, {1'b1, 32'h1000_0003});
        tick();
        check("t5_empty", trc_valid, 1'b0);
        trc_ready = 1'b0;

        // Stray txn while idle.
        mem_txn(1'b0, 32'h200, 32'h0, 32'h0);
        tick();
        check("t6_stray", trc_stray, 1'b1);
        check("t6_norec", trc_valid, 1'b0);

        // Reset mid-instruction with a record pending.
        accept(32'h0000_700B, 32'h0);
        respond(3'd0, 1'b0, 5'd0, 32'h0);
        accept(32'h0000_800B, 32'h0);
        check("t7_pre", trc_valid, 1'b1);
        g_reset = 1'b1;
        #1;
        check("t7_valid", trc_valid, 1'b0);
        check("t7_stray", trc_stray, 1'b0);
        check("t7_drop", trc_drop_cnt, 8'd0);
        check("t7_enc", trc_enc, 32'h0);
        tick();
        g_reset = 1'b0;
        tick();
        check("t7_after", trc_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scarv_cop_txn_monitor.md
Name: scarv_cop_txn_monitor

Overview:
- Synthesisable, parametrised transaction monitor for the COP.
- Observes the CPU/COP instruction handshake and the COP memory interface.
- Assembles one record per completed or aborted instruction: encoding, rs1, result, writeback and up to MEM_DEPTH memory transactions.
- Queues records in a TXN_FIFO_DEPTH FIFO drained by a valid/ready stream; feeds both the formal checkers and the on-chip trace unit.

Parameters:
MEM_DEPTH, 4, memory transaction slots per record (1..8)
TXN_FIFO_DEPTH, 4, record FIFO entries (power of two, >=2)
DROP_W, 8, width of saturating dropped-record counter

Ports:
g_clk  in  1  global clock
g_reset  in  1  asynchronous active-high reset
cpu_insn_req  in  1  instruction request
cop_insn_ack  in  1  instruction request acknowledge
cpu_abort_req  in  1  abort current instruction
cpu_insn_enc  in  32  instruction encoding
cpu_rs1  in  32  rs1 source data
cop_insn_rsp  in  1  COP instruction finished
cpu_insn_ack  in  1  finish acknowledge
cop_result  in  3  execution result
cop_wen  in  1  GPR write enable
cop_waddr  in  5  GPR write address
cop_wdata  in  32  GPR write data
cop_mem_cen  in  1  memory chip enable
cop_mem_wen  in  1  memory write enable
cop_mem_addr  in  32  memory address
cop_mem_wdata  in  32  memory write data
cop_mem_ben  in  4  byte enables
cop_mem_rdata  in  32  memory read data
cop_mem_stall  in  1  memory stall
cop_mem_error  in  1  memory error
trc_valid  out  1  record available
trc_ready  in  1  consumer accepts record
trc_enc  out  32  record encoding
trc_rs1  out  32  record rs1
trc_result  out  3  record result (0 if aborted)
trc_wen / trc_waddr / trc_wdata  out  1/5/32  record writeback
trc_aborted  out  1  instruction aborted
trc_mem_cnt  out  $clog2(MEM_DEPTH)+2  memory txns seen (saturating)
trc_mem_ovf  out  1  more than MEM_DEPTH txns seen
trc_mem_wen  out  MEM_DEPTH  per-slot write flag
trc_mem_err  out  MEM_DEPTH  per-slot error flag
trc_mem_ben  out  4*MEM_DEPTH  per-slot byte enables
trc_mem_addr / trc_mem_wdata / trc_mem_rdata  out  32*MEM_DEPTH  per-slot data, slot 0 in LSBs
trc_drop_cnt  out  DROP_W  records dropped on FIFO full (saturating)
trc_stray  out  1  sticky: memory txn seen while IDLE

Behaviour:
- Reset: g_reset asynchronous and active-high; clears FSM, FIFO pointers, counters, trc_stray. All trc_* outputs are 0 during and after reset.
- FSM IDLE -> ACTIVE on cpu_insn_req && cop_insn_ack: latch enc/rs1, clear the slot count.
- ACTIVE -> IDLE on cop_insn_rsp && cpu_insn_ack: latch result/wen/waddr/wdata and push the record. If cpu_insn_req && cop_insn_ack are also asserted that cycle, enter ACTIVE with the new instruction instead.
- ACTIVE with cpu_abort_req: push the record with trc_aborted=1 and result/writeback fields 0, then -> IDLE. If the response handshake occurs in the same cycle, it wins and aborted=0.
- Memory txn completes in a cycle with cop_mem_cen && !cop_mem_stall. addr/wen/wdata/ben/rdata/error are sampled that cycle into slot trc_mem_cnt if trc_mem_cnt < MEM_DEPTH. A txn completing in the same cycle as the response is included.
- Slot overflow: trc_mem_cnt keeps counting, saturating at its maximum; trc_mem_ovf=1; stored slots are unchanged. Unused slots read 0.
- Txn completing in IDLE: not recorded; sets trc_stray.
- FIFO: push on record close; pop on trc_valid && trc_ready. Record reaches the output at the earliest 1 cycle after close. Simultaneous push and pop when full is allowed (no drop).
- Push when full without pop: record discarded; trc_drop_cnt increments, saturating at 2^DROP_W-1.
- trc_* data is stable while trc_valid && !trc_ready.

Optional Feature:
- TXN_MONITOR_TIMESTAMP_EN defined: adds a free-running 32-bit cycle counter (wraps) and outputs trc_t_start[31:0] (counter at accept) and trc_t_end[31:0] (counter at close), stored per record.
- Not defined: ports absent, counter not instantiated.

Test Plan:
- Single instruction (enc=0x0000_100B, rs1=0x1234), 2 reads (addr 0x100, 0x104; rdata 0xAA, 0xBB), rsp result=0, wdata=0x55 -> one record: mem_cnt=2, slot0 addr 0x100/rdata 0xAA, slot1 0x104/0xBB, wen=1, wdata=0x55.
- 6 memory txns with MEM_DEPTH=4 -> mem_cnt=6, mem_ovf=1, slots 0..3 hold the first four addresses.
- trc_ready=0 for 6 instructions with TXN_FIFO_DEPTH=4 -> 4 records retained, drop_cnt=2. Draining then gives the first four in order.
- Abort after 1 write txn -> record with aborted=1, result=0, mem_cnt=1, slot0 wen=1.
- Response and new request in the same cycle, twice -> 3 consecutive records with no gap, each with the correct enc.
- Txn while IDLE -> stray=1 and no record. Assert g_reset mid-instruction -> trc_valid=0 immediately, stray/drop_cnt=0.
